dcache_arbiter: RTL
===================

Name: dcache_arbiter

Overview:
- Sequences and shares the single-ported data cache between two requesters: the pipeline MEM stage (cpu port) and the debug/program-loader port (dbg port).
- Registers the winning request onto the cache control/address/data lines and captures the registered read data one cycle later.
- Returns a one-cycle ack to the winner and drives a stall to the pipeline while a cpu access is outstanding.

Parameters:
- ADDR_W, 32, address width of both ports and the cache.
- DATA_W, 32, data width.
- DBG_MAX_WAIT, 8, cpu-won arbitrations dbg may lose before dbg is forced to win (range 1..255).
- STAT_W, 16, width of the optional grant counters.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  cpu access request; held with fields stable until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  cpu address.
- cpu_wdata  in  DATA_W  cpu write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read result; valid with cpu_ack, held until the next cpu read ack.
- cpu_stall  out  1  = cpu_req & ~cpu_ack (combinational).
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata  same as cpu_*; no stall output.
- dc_mem_write  out  1  cache write enable.
- dc_mem_read  out  1  cache read enable.
- dc_mem_to_reg  out  1  high during cpu-port reads only.
- dc_address  out  ADDR_W  cache address.
- dc_write_data  out  DATA_W  cache write data.
- dc_read_data  in  DATA_W  cache read data; registered, valid the cycle after dc_mem_read.

Behaviour:
- Reset (async, reset_n = 0):
  - State is IDLE; all outputs 0; starvation counter 0; in-flight transaction dropped with no ack.
  - Outputs stay 0 until the first cycle after reset_n rises.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If any req is high, select a winner, latch its we/addr/wdata/port id, and go to ACCESS. Otherwise stay in IDLE.
- Arbitration:
  - cpu wins by default.
  - dbg wins if only dbg requests, or if both request and the starvation counter equals DBG_MAX_WAIT.
  - Counter increments when both request and cpu wins; clears when dbg wins; saturates at DBG_MAX_WAIT.
- ACCESS:
  - dc_* outputs driven from the latched registers: dc_mem_write = we, dc_mem_read = ~we, dc_mem_to_reg = ~we & (port == cpu).
  - Always go to RESP.
- RESP:
  - All dc_* enables are 0.
  - On a read, dc_read_data is captured into the winner's rdata register.
  - The winner's ack pulses for exactly this cycle.
  - Go to IDLE.
- Latency: req sampled in IDLE at cycle N; dc enables asserted in N+1; ack in N+2. Throughput is one access per 3 cycles.
- req lines are ignored in ACCESS and RESP. A requester that keeps req high after its ack is presenting a new transaction, sampled in the next IDLE.
- Both ack outputs are never high together.
- Only the winner's rdata updates. The loser's fields are not sampled.
- Writes do not change rdata.
- Addresses and data pass unmodified; no alignment check; address wrap is not applicable.
- Simultaneous requests: handled per the arbitration rule. When dbg wins, cpu_stall remains high through dbg's access.

Optional Feature:
- Macro: DCACHE_ARB_STATS_EN.
- Defined:
  - Adds outputs cpu_grant_cnt and dbg_grant_cnt (out, STAT_W each).
  - Each increments on entry to ACCESS for its port, wraps modulo 2^STAT_W, and resets to 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package dcache_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}.
  - port-id constants PORT_CPU = 0, PORT_DBG = 1.
  - Default widths.
- One sub-module: dcache_arb_prio. It is combinational-plus-counter: takes both reqs, outputs the winner, and owns the starvation counter.

Test Plan:
- cpu read:
  - Stimulus: cache preloaded 0x100 = 0xDEADBEEF; cpu_req = 1, we = 0, addr = 0x100 at cycle 0.
  - Response: dc_mem_read = 1 and dc_mem_to_reg = 1 at cycle 1; cpu_ack = 1 and cpu_rdata = 0xDEADBEEF at cycle 2; cpu_stall high for cycles 0-1.
- dbg write then cpu read:
  - Stimulus: dbg writes 0x55AA55AA to 0x40; then cpu reads 0x40.
  - Response: dbg_ack at cycle 2; cpu_rdata = 0x55AA55AA; dc_mem_to_reg stays 0 during the dbg access.
- Starvation:
  - Stimulus: cpu_req and dbg_req held high continuously, DBG_MAX_WAIT = 8.
  - Response: 8 cpu acks, then 1 dbg ack, then the pattern repeats.
- Simultaneous single requests:
  - Stimulus: both requests in the same cycle, counter = 0.
  - Response: cpu acked at cycle 2, dbg acked at cycle 5, no overlap of acks.
- Reset mid-access:
  - Stimulus: reset_n low during ACCESS.
  - Response: all dc_* and acks 0 immediately; no ack after release; a fresh request completes normally.
- Stats (DCACHE_ARB_STATS_EN defined):
  - Stimulus: 3 cpu and 2 dbg accesses.
  - Response: cpu_grant_cnt = 3, dbg_grant_cnt = 2; both 0 after reset.

Source files
------------

// File: rtl/dcache_arb_pkg.sv
// Shared constants for the data-cache arbiter: default widths, FSM encodings and port ids.
package dcache_arb_pkg;

  localparam int ADDR_W_DEF       = 32;
  localparam int DATA_W_DEF       = 32;
  localparam int DBG_MAX_WAIT_DEF = 8;
  localparam int STAT_W_DEF       = 16;

  // Starvation counter width covers the full 1..255 DBG_MAX_WAIT range
  localparam int CNT_W = 8;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/dcache_arb_prio.sv
// Winner selection between cpu and dbg, plus the counter that keeps dbg from
// being starved while both ports keep requesting.
module dcache_arb_prio
  import dcache_arb_pkg::*;
#(
  parameter int DBG_MAX_WAIT = DBG_MAX_WAIT_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic cpu_req,
  input  logic dbg_req,
  input  logic arb_en,
  output logic grant_dbg
);

  localparam logic [CNT_W-1:0] MAX_WAIT = CNT_W'(DBG_MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;

  // The counter only moves on cycles where a grant is actually committed
  always_comb begin
    grant_dbg  = dbg_req & (~cpu_req | (wait_cnt_q == MAX_WAIT));
    wait_cnt_d = wait_cnt_q;
    if (arb_en) begin
      if (grant_dbg) begin
        wait_cnt_d = '0;
      end else if (dbg_req && (wait_cnt_q != MAX_WAIT)) begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/dcache_arbiter.sv
// Shares the single-ported data cache between the MEM stage and the debug port.
// Optional grant counters are enabled with `define DCACHE_ARB_STATS_EN.
module dcache_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int DBG_MAX_WAIT = DBG_MAX_WAIT_DEF
`ifdef DCACHE_ARB_STATS_EN
  ,
  parameter int STAT_W       = STAT_W_DEF
`endif
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dc_mem_write,
  output logic              dc_mem_read,
  output logic              dc_mem_to_reg,
  output logic [ADDR_W-1:0] dc_address,
  output logic [DATA_W-1:0] dc_write_data,
  input  logic [DATA_W-1:0] dc_read_data
`ifdef DCACHE_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] cpu_grant_cnt,
  output logic [STAT_W-1:0] dbg_grant_cnt
`endif
);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic              port_q, port_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              arb_en;
  logic              grant_dbg;
  logic              in_access;
  logic              in_resp;

  assign arb_en = (state_q == ST_IDLE) & (cpu_req | dbg_req);

  dcache_arb_prio #(
    .DBG_MAX_WAIT(DBG_MAX_WAIT)
  ) u_prio (
    .clock    (clock),
    .reset_n  (reset_n),
    .cpu_req  (cpu_req),
    .dbg_req  (dbg_req),
    .arb_en   (arb_en),
    .grant_dbg(grant_dbg)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    port_d      = port_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_en) begin
          state_d = ST_ACCESS;
          port_d  = grant_dbg ? PORT_DBG : PORT_CPU;
          we_d    = grant_dbg ? dbg_we    : cpu_we;
          addr_d  = grant_dbg ? dbg_addr  : cpu_addr;
          wdata_d = grant_dbg ? dbg_wdata : cpu_wdata;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP: begin
        state_d = ST_IDLE;
        if (!we_q) begin
          if (port_q == PORT_DBG) dbg_rdata_d = dc_read_data;
          else                    cpu_rdata_d = dc_read_data;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      port_q      <= PORT_CPU;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      port_q      <= port_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign in_access     = (state_q == ST_ACCESS);
  assign in_resp       = (state_q == ST_RESP);
  assign dc_mem_write  = in_access & we_q;
  assign dc_mem_read   = in_access & ~we_q;
  assign dc_mem_to_reg = in_access & ~we_q & (port_q == PORT_CPU);
  assign dc_address    = addr_q;
  assign dc_write_data = wdata_q;
  assign cpu_ack       = in_resp & (port_q == PORT_CPU);
  assign dbg_ack       = in_resp & (port_q == PORT_DBG);
  assign cpu_stall     = cpu_req & ~cpu_ack;

  // Read data is bypassed during the ack cycle so it is valid together with the ack
  assign cpu_rdata = (cpu_ack & ~we_q) ? dc_read_data : cpu_rdata_q;
  assign dbg_rdata = (dbg_ack & ~we_q) ? dc_read_data : dbg_rdata_q;

`ifdef DCACHE_ARB_STATS_EN
  logic [STAT_W-1:0] cpu_grant_cnt_q, cpu_grant_cnt_d;
  logic [STAT_W-1:0] dbg_grant_cnt_q, dbg_grant_cnt_d;

  always_comb begin
    cpu_grant_cnt_d = cpu_grant_cnt_q;
    dbg_grant_cnt_d = dbg_grant_cnt_q;
    if (arb_en) begin
      if (grant_dbg) dbg_grant_cnt_d = dbg_grant_cnt_q + STAT_W'(1);
      else           cpu_grant_cnt_d = cpu_grant_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cpu_grant_cnt_q <= '0;
      dbg_grant_cnt_q <= '0;
    end else begin
      cpu_grant_cnt_q <= cpu_grant_cnt_d;
      dbg_grant_cnt_q <= dbg_grant_cnt_d;
    end
  end

  assign cpu_grant_cnt = cpu_grant_cnt_q;
  assign dbg_grant_cnt = dbg_grant_cnt_q;
`endif

endmodule
